mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port word memory (10-bit word addr, rw_mode 1=read/0=write,
//  byte enables, 1-cycle registered read) between the core's instruction-fetch (IF)
//  and data (DM) ports. Arbitrates, converts byte addresses and RV32 sizes into
//  word address, byte lanes and aligned write data, and returns extracted,
//  sign/zero-extended load data one cycle after grant. Sits between core and memory.
// PARAMETERS
//  MEM_AW      10  memory word-address width; word addr = byte_addr[MEM_AW+1:2]
//  DM_PRIORITY 0   0 = round-robin on conflict; 1 = DM always wins on conflict
// PORTS
//  i_clk            in   1   clock
//  i_rst            in   1   reset, asynchronous, active-high
//  in_if_req        in   1   IF read request
//  in_if_addr       in   32  IF byte address (word-aligned expected)
//  out_if_gnt       out  1   IF request accepted this cycle
//  out_if_rvalid    out  1   IF response valid (cycle after gnt)
//  out_if_rdata     out  32  IF read word
//  in_dm_req        in   1   DM request
//  in_dm_we         in   1   1 = store, 0 = load
//  in_dm_addr       in   32  DM byte address
//  in_dm_size       in   2   00 byte, 01 half, 10 word (11 illegal -> err)
//  in_dm_unsigned   in   1   load zero-extend (LBU/LHU)
//  in_dm_wdata      in   32  store data, LSB-justified
//  out_dm_gnt       out  1   DM request accepted this cycle
//  out_dm_rvalid    out  1   DM response valid (loads and stores)
//  out_dm_rdata     out  32  extended load data; 0 for stores/err
//  out_dm_err       out  1   with rvalid: misaligned or illegal size
//  out_mem_addr     out  MEM_AW  memory word address
//  out_mem_rw_mode  out  1   1 read, 0 write
//  out_mem_write_data out 32 lane-replicated store data
//  out_mem_byte_en  out  4   byte lanes for store
//  in_mem_data      in   32  memory registered read data
// BEHAVIOUR
//  - Memory writes every cycle rw_mode=0: out_mem_rw_mode=1 except in a granted,
//    aligned store cycle. Reset and idle: rw_mode=1, byte_en=0, addr=0, wdata=0.
//  - gnt combinational from req and RR pointer; at most one gnt per cycle; req
//    without gnt must be held (inputs stable) by requester.
//  - Conflict: DM_PRIORITY=1 -> DM. Else RR: winner = requester not served last
//    conflict; pointer updates only on conflict cycles. Reset pointer -> DM first.
//  - Fully pipelined: one grant per cycle, response exactly 1 cycle after gnt;
//    response register holds {owner, offset[1:0], size, unsigned, err, is_store}.
//  - Load: lanes picked by addr[1:0]; byte/half sign-extended unless unsigned;
//    data taken from in_mem_data in rvalid cycle (not registered again).
//  - Store: byte_en = 0001<<a, 0011<<a, 1111; wdata replicated (byte x4, half x2).
//  - Misaligned (half a[0]=1, word a[1:0]!=0) or size=11: granted, no memory
//    access (rw_mode stays 1, byte_en 0), rvalid+err next cycle, rdata 0.
//  - IF misaligned: low 2 bits ignored, no err path.
//  - Addr bits above MEM_AW+1 ignored (wrap-around).
//  - Reset mid-operation: pending response dropped, all rvalid/err/rdata -> 0.
// STRUCTURE
//  - mem_arb_pkg: size enum (SZ_B/SZ_H/SZ_W), owner enum (OWN_IF/OWN_DM),
//    resp_t struct, byte_en constants.
//  - Sub-module mem_lane_align: combinational store lane/data generation and
//    load extract/extend; arbiter holds FSM-free pipeline and RR pointer.
// TESTING
//  - IF only, addr 0x10 -> gnt same cycle, mem_addr=4, rvalid next cycle with in_mem_data.
//  - SB 0xA5 to 0x103 -> byte_en=1000, wdata=A5A5A5A5, rw_mode=0 one cycle, rvalid+err=0.
//  - LB from 0x102, mem=0x0080_0000 -> rdata=0xFFFFFF80; LBU -> 0x00000080.
//  - LW at 0x6 -> err=1, rvalid next cycle, rw_mode held 1, no memory write.
//  - IF+DM every cycle, DM_PRIORITY=0 -> grants alternate DM,IF,DM...; =1 -> DM only.
//  - Assert i_rst with grant in flight -> rvalid=0 next cycle, rw_mode=1 immediately.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory arbiter slice.
// The size and owner enums, the registered response record and the byte-lane
// masks live here so the arbiter and the lane aligner agree on encodings.
package mem_arb_pkg;

   // RV32 access size as carried on the data port; SZ_X is the illegal encoding
   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_e;

   // Which port owns the response slot
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   // Everything needed one cycle after grant to steer and shape the response
   typedef struct packed {
      logic       valid;
      owner_e     owner;
      logic [1:0] offset;
      size_e      size;
      logic       unsignedLd;
      logic       err;
      logic       isStore;
   } resp_t;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // A data access is refused (granted with err, no memory traffic) when the
   // size is illegal or the byte offset does not suit the access size.
   function automatic logic isBadAccess(input size_e size, input logic [1:0] offset);
      logic bad;
      bad = 1'b1;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = offset[0];
         SZ_W:    bad = (offset != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the shared word memory.
// Store side: builds byte enables from size/offset and replicates the
// LSB-justified store data across lanes. Load side: picks the addressed byte
// or halfword out of the returned word and sign- or zero-extends it.
// Purely combinational; the arbiter decides when the results are used.
module mem_lane_align
   import mem_arb_pkg::*;
(
   input  size_e       stSize_i,
   input  logic [1:0]  stOffset_i,
   input  logic [31:0] stData_i,
   output logic [3:0]  stByteEn_o,
   output logic [31:0] stData_o,
   input  size_e       ldSize_i,
   input  logic [1:0]  ldOffset_i,
   input  logic        ldUnsigned_i,
   input  logic [31:0] ldMemData_i,
   output logic [31:0] ldData_o
);

   logic [7:0]  ldByte;
   logic [15:0] ldHalf;

   // Store lanes: shift the size mask to the offset, replicate data per size
   always_comb begin
      stByteEn_o = BE_NONE;
      stData_o   = '0;
      case (stSize_i)
         SZ_B: begin
            stByteEn_o = BE_BYTE << stOffset_i;
            stData_o   = {4{stData_i[7:0]}};
         end
         SZ_H: begin
            stByteEn_o = BE_HALF << stOffset_i;
            stData_o   = {2{stData_i[15:0]}};
         end
         SZ_W: begin
            stByteEn_o = BE_WORD;
            stData_o   = stData_i;
         end
         default: begin
            stByteEn_o = BE_NONE;
            stData_o   = '0;
         end
      endcase
   end

   // Load extract: select the addressed lane(s), then extend to 32 bits
   always_comb begin
      ldByte   = 8'h00;
      ldHalf   = 16'h0000;
      ldData_o = '0;
      case (ldOffset_i)
         2'd0:    ldByte = ldMemData_i[7:0];
         2'd1:    ldByte = ldMemData_i[15:8];
         2'd2:    ldByte = ldMemData_i[23:16];
         default: ldByte = ldMemData_i[31:24];
      endcase
      ldHalf = ldOffset_i[1] ? ldMemData_i[31:16] : ldMemData_i[15:0];
      case (ldSize_i)
         SZ_B:    ldData_o = {{24{ldByte[7] & ~ldUnsigned_i}}, ldByte};
         SZ_H:    ldData_o = {{16{ldHalf[15] & ~ldUnsigned_i}}, ldHalf};
         SZ_W:    ldData_o = ldMemData_i;
         default: ldData_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port word memory between instruction fetch (IF)
// and data (DM) ports. Grants are combinational, one per cycle; the response
// for a grant appears exactly one cycle later, steered by a small response
// register. Conflicts go round-robin (DM first out of reset) or always to DM.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_AW      = 10,
   parameter bit          DM_PRIORITY = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              in_if_req,
   input  logic [31:0]       in_if_addr,
   output logic              out_if_gnt,
   output logic              out_if_rvalid,
   output logic [31:0]       out_if_rdata,
   input  logic              in_dm_req,
   input  logic              in_dm_we,
   input  logic [31:0]       in_dm_addr,
   input  logic [1:0]        in_dm_size,
   input  logic              in_dm_unsigned,
   input  logic [31:0]       in_dm_wdata,
   output logic              out_dm_gnt,
   output logic              out_dm_rvalid,
   output logic [31:0]       out_dm_rdata,
   output logic              out_dm_err,
   output logic [MEM_AW-1:0] out_mem_addr,
   output logic              out_mem_rw_mode,
   output logic [31:0]       out_mem_write_data,
   output logic [3:0]        out_mem_byte_en,
   input  logic [31:0]       in_mem_data
);

   logic        ifGnt;
   logic        dmGnt;
   logic        conflict;
   logic        rrDmNext_q;
   logic        rrDmNext_d;
   size_e       dmSize;
   logic        dmBad;
   logic        dmStoreOk;
   resp_t       resp_q;
   resp_t       resp_d;
   logic [3:0]  laneByteEn;
   logic [31:0] laneStData;
   logic [31:0] laneLdData;
   logic        ifRvalid;
   logic        dmRvalid;
   logic        unusedAddrBits;

   assign dmSize    = size_e'(in_dm_size);
   assign dmBad     = isBadAccess(dmSize, in_dm_addr[1:0]);
   assign conflict  = in_if_req & in_dm_req & ~i_rst;
   assign dmStoreOk = dmGnt & in_dm_we & ~dmBad;

   // IF ignores its low address bits and both ports wrap above the memory size
   assign unusedAddrBits = ^{in_if_addr[1:0], in_if_addr[31:MEM_AW+2], in_dm_addr[31:MEM_AW+2]};

   // Grant selection: a lone requester always wins; a conflict follows priority/pointer
   always_comb begin
      ifGnt = 1'b0;
      dmGnt = 1'b0;
      if (!i_rst) begin
         if (conflict) begin
            if (DM_PRIORITY || rrDmNext_q) begin
               dmGnt = 1'b1;
            end else begin
               ifGnt = 1'b1;
            end
         end else begin
            ifGnt = in_if_req;
            dmGnt = in_dm_req;
         end
      end
   end

   assign out_if_gnt = ifGnt;
   assign out_dm_gnt = dmGnt;

   // Round-robin pointer moves only on conflicts: the loser goes first next time
   always_comb begin
      rrDmNext_d = rrDmNext_q;
      if (conflict) begin
         rrDmNext_d = ifGnt;
      end
   end

   // Pointer register; DM is favoured on the first conflict after reset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rrDmNext_q <= 1'b1;
      end else begin
         rrDmNext_q <= rrDmNext_d;
      end
   end

   mem_lane_align u_lane (
      .stSize_i     (dmSize),
      .stOffset_i   (in_dm_addr[1:0]),
      .stData_i     (in_dm_wdata),
      .stByteEn_o   (laneByteEn),
      .stData_o     (laneStData),
      .ldSize_i     (resp_q.size),
      .ldOffset_i   (resp_q.offset),
      .ldUnsigned_i (resp_q.unsignedLd),
      .ldMemData_i  (in_mem_data),
      .ldData_o     (laneLdData)
   );

   // Memory request: read by default, write only for a granted well-formed store
   always_comb begin
      out_mem_addr       = '0;
      out_mem_rw_mode    = 1'b1;
      out_mem_byte_en    = BE_NONE;
      out_mem_write_data = '0;
      if (ifGnt) begin
         out_mem_addr = in_if_addr[MEM_AW+1:2];
      end else if (dmGnt && !dmBad) begin
         out_mem_addr = in_dm_addr[MEM_AW+1:2];
      end
      if (dmStoreOk) begin
         out_mem_rw_mode    = 1'b0;
         out_mem_byte_en    = laneByteEn;
         out_mem_write_data = laneStData;
      end
   end

   // Capture what the response cycle needs to know about this cycle's grant
   always_comb begin
      resp_d = '0;
      if (ifGnt) begin
         resp_d.valid = 1'b1;
         resp_d.owner = OWN_IF;
         resp_d.size  = SZ_W;
      end else if (dmGnt) begin
         resp_d.valid      = 1'b1;
         resp_d.owner      = OWN_DM;
         resp_d.offset     = in_dm_addr[1:0];
         resp_d.size       = dmSize;
         resp_d.unsignedLd = in_dm_unsigned;
         resp_d.err        = dmBad;
         resp_d.isStore    = in_dm_we;
      end
   end

   // Response register; reset drops any response still in flight
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         resp_q <= '0;
      end else begin
         resp_q <= resp_d;
      end
   end

   // Response steering; memory data is used directly in the response cycle
   always_comb begin
      ifRvalid      = resp_q.valid && (resp_q.owner == OWN_IF);
      dmRvalid      = resp_q.valid && (resp_q.owner == OWN_DM);
      out_if_rvalid = ifRvalid;
      out_if_rdata  = ifRvalid ? in_mem_data : '0;
      out_dm_rvalid = dmRvalid;
      out_dm_err    = dmRvalid && resp_q.err;
      out_dm_rdata  = '0;
      if (dmRvalid && !resp_q.err && !resp_q.isStore) begin
         out_dm_rdata = laneLdData;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a driver issues directed and random
// IF/DM traffic, predicts grants and responses from a byte-addressed golden
// memory, and queues the expectations; a monitor compares DUT outputs.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int MEM_AW = 10;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
   } dmTxn_t;

   typedef struct packed {
      logic        ifGnt;
      logic        dmGnt;
      logic        priIfGnt;
      logic        priDmGnt;
      logic        rw;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        chkAddr;
      logic [9:0]  addr;
      logic        rstLate;
   } cycExp_t;

   typedef struct packed {
      logic [31:0] cyc;
      logic        isDm;
      logic        err;
      logic [31:0] data;
   } respExp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ifReq = 1'b0;
   logic [31:0] ifAddr = '0;
   logic        dmReq = 1'b0;
   logic        dmWe = 1'b0;
   logic [31:0] dmAddr = '0;
   logic [1:0]  dmSize = '0;
   logic        dmUnsigned = 1'b0;
   logic [31:0] dmWdata = '0;
   logic [31:0] memRdata;
   logic        ifGnt, ifRvalid, dmGnt, dmRvalid, dmErr, memRw;
   logic [31:0] ifRdata, dmRdata, memWdata;
   logic [MEM_AW-1:0] memAddr;
   logic [3:0]  memBe;

   logic        priIfGnt, priDmGnt;
   logic        unusedPriIfRvalid, unusedPriDmRvalid, unusedPriDmErr, unusedPriRw;
   logic [31:0] unusedPriIfRdata, unusedPriDmRdata, unusedPriWdata;
   logic [MEM_AW-1:0] unusedPriAddr;
   logic [3:0]  unusedPriBe;

   logic [31:0] sram [0:1023];
   logic [7:0]  gold [0:4095];
   logic        fillMem = 1'b1;

   cycExp_t     cycQ[$];
   respExp_t    respQ[$];
   logic [31:0] ifDirQ[$];
   dmTxn_t      dmDirQ[$];

   int          cycNow = 0;
   int          checkCount = 0;
   int          passCount = 0;
   bit          dmTurn = 1'b1;
   bit          ifPend = 1'b0;
   bit          dmPend = 1'b0;
   logic [31:0] pendIf = '0;
   dmTxn_t      pendDm = '0;

   always #5 clock = ~clock;

   mem_arbiter #(.MEM_AW(MEM_AW), .DM_PRIORITY(1'b0)) dut (
      .i_clk(clock), .i_rst(reset),
      .in_if_req(ifReq), .in_if_addr(ifAddr), .out_if_gnt(ifGnt),
      .out_if_rvalid(ifRvalid), .out_if_rdata(ifRdata),
      .in_dm_req(dmReq), .in_dm_we(dmWe), .in_dm_addr(dmAddr), .in_dm_size(dmSize),
      .in_dm_unsigned(dmUnsigned), .in_dm_wdata(dmWdata), .out_dm_gnt(dmGnt),
      .out_dm_rvalid(dmRvalid), .out_dm_rdata(dmRdata), .out_dm_err(dmErr),
      .out_mem_addr(memAddr), .out_mem_rw_mode(memRw), .out_mem_write_data(memWdata),
      .out_mem_byte_en(memBe), .in_mem_data(memRdata)
   );

   // Fixed-priority variant sees the same inputs; only its grants are checked
   mem_arbiter #(.MEM_AW(MEM_AW), .DM_PRIORITY(1'b1)) dutPri (
      .i_clk(clock), .i_rst(reset),
      .in_if_req(ifReq), .in_if_addr(ifAddr), .out_if_gnt(priIfGnt),
      .out_if_rvalid(unusedPriIfRvalid), .out_if_rdata(unusedPriIfRdata),
      .in_dm_req(dmReq), .in_dm_we(dmWe), .in_dm_addr(dmAddr), .in_dm_size(dmSize),
      .in_dm_unsigned(dmUnsigned), .in_dm_wdata(dmWdata), .out_dm_gnt(priDmGnt),
      .out_dm_rvalid(unusedPriDmRvalid), .out_dm_rdata(unusedPriDmRdata), .out_dm_err(unusedPriDmErr),
      .out_mem_addr(unusedPriAddr), .out_mem_rw_mode(unusedPriRw), .out_mem_write_data(unusedPriWdata),
      .out_mem_byte_en(unusedPriBe), .in_mem_data(memRdata)
   );

   function automatic logic [7:0] initByte(input int i);
      return 8'((i * 37) ^ (i >> 4) ^ 8'h5A);
   endfunction

   // Word memory model with byte-enabled writes and a registered read
   always @(posedge clock) begin
      if (fillMem) begin
         for (int w = 0; w < 1024; w++) begin
            sram[w] <= {initByte(4*w+3), initByte(4*w+2), initByte(4*w+1), initByte(4*w)};
         end
      end else if (!memRw) begin
         for (int l = 0; l < 4; l++) begin
            if (memBe[l]) sram[memAddr][8*l +: 8] <= memWdata[8*l +: 8];
         end
      end
      memRdata <= sram[memAddr];
   end

   function automatic int nBytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

   function automatic logic dmLegal(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd3) return 1'b0;
      return (a % nBytes(sz)) == 0;
   endfunction

   function automatic logic [31:0] goldWord(input logic [31:0] a);
      int idx;
      idx = int'({a[11:2], 2'b00});
      return {gold[idx+3], gold[idx+2], gold[idx+1], gold[idx]};
   endfunction

   function automatic logic [31:0] loadValue(input int base, input int n, input logic uns);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v = v | (32'(gold[base+k]) << (8*k));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   function automatic dmTxn_t mkDm(input logic we, input logic [31:0] a, input logic [1:0] sz,
                                   input logic uns, input logic [31:0] wd);
      dmTxn_t t;
      t.we = we; t.addr = a; t.size = sz; t.uns = uns; t.wdata = wd;
      return t;
   endfunction

   function automatic dmTxn_t randomDm();
      dmTxn_t t;
      int r;
      logic [31:0] a;
      r = int'($urandom_range(15));
      t.size = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      a = $urandom;
      if ($urandom_range(3) != 0) a[11:0] = 12'($urandom_range(63));
      if ($urandom_range(3) != 0 && t.size != 2'd3) a = a & ~(32'(nBytes(t.size)) - 32'd1);
      t.addr  = a;
      t.we    = 1'($urandom_range(1));
      t.uns   = 1'($urandom_range(1));
      t.wdata = $urandom;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycNow);
   endtask

   // One driver cycle: pick new work, drive it, predict grants and responses
   task automatic applyStimulus(input int pIf, input int pDm);
      cycExp_t  e;
      respExp_t r;
      bit       gIf, gDm;
      int       n, base;
      @(negedge clock);
      reset = 1'b0;
      cycNow++;
      if (!ifPend) begin
         if (ifDirQ.size() > 0) begin pendIf = ifDirQ.pop_front(); ifPend = 1'b1; end
         else if (int'($urandom_range(99)) < pIf) begin pendIf = $urandom; ifPend = 1'b1; end
      end
      if (!dmPend) begin
         if (dmDirQ.size() > 0) begin pendDm = dmDirQ.pop_front(); dmPend = 1'b1; end
         else if (int'($urandom_range(99)) < pDm) begin pendDm = randomDm(); dmPend = 1'b1; end
      end
      ifReq = ifPend; ifAddr = pendIf;
      dmReq = dmPend; dmWe = pendDm.we; dmAddr = pendDm.addr; dmSize = pendDm.size;
      dmUnsigned = pendDm.uns; dmWdata = pendDm.wdata;

      gIf = ifPend; gDm = dmPend;
      if (ifPend && dmPend) begin
         gDm = dmTurn; gIf = !dmTurn; dmTurn = !dmTurn;
      end
      e = '0;
      e.ifGnt = gIf; e.dmGnt = gDm;
      e.priDmGnt = dmPend; e.priIfGnt = ifPend && !dmPend;
      e.rw = 1'b1; e.chkAddr = 1'b1; e.addr = '0;
      if (gIf) begin
         e.addr = pendIf[11:2];
         r = '0; r.cyc = cycNow; r.isDm = 1'b0; r.data = goldWord(pendIf);
         respQ.push_back(r);
         ifPend = 1'b0;
      end
      if (gDm) begin
         r = '0; r.cyc = cycNow; r.isDm = 1'b1;
         if (!dmLegal(pendDm.size, pendDm.addr)) begin
            e.chkAddr = 1'b0; r.err = 1'b1;
         end else begin
            e.addr = pendDm.addr[11:2];
            n = nBytes(pendDm.size);
            base = int'(pendDm.addr[11:0]);
            if (pendDm.we) begin
               e.rw = 1'b0;
               for (int k = 0; k < n; k++) e.be[2'((base + k) % 4)] = 1'b1;
               for (int l = 0; l < 4; l++) e.wd[8*l +: 8] = pendDm.wdata[8*(l % n) +: 8];
               for (int k = 0; k < n; k++) gold[base+k] = pendDm.wdata[8*k +: 8];
            end else begin
               r.data = loadValue(base, n, pendDm.uns);
            end
         end
         respQ.push_back(r);
         dmPend = 1'b0;
      end
      cycQ.push_back(e);
   endtask

   // Grant a store, then pull reset before the clock edge that would write it
   task automatic resetInFlight();
      cycExp_t e;
      @(negedge clock);
      reset = 1'b0;
      cycNow++;
      ifPend = 1'b0; dmPend = 1'b0;
      ifReq = 1'b0; dmReq = 1'b1; dmWe = 1'b1; dmAddr = 32'h0000_0204;
      dmSize = 2'd2; dmUnsigned = 1'b0; dmWdata = 32'hDEAD_BEEF;
      e = '0;
      e.dmGnt = 1'b1; e.priDmGnt = 1'b1; e.rw = 1'b0; e.be = 4'hF; e.wd = 32'hDEAD_BEEF;
      e.chkAddr = 1'b1; e.addr = 10'h081; e.rstLate = 1'b1;
      cycQ.push_back(e);
      #3 reset = 1'b1;
      @(negedge clock);
      cycNow++;
      e = '0; e.rw = 1'b1; e.chkAddr = 1'b1;
      cycQ.push_back(e);
      dmTurn = 1'b1;
   endtask

   // Monitor: compare grants, memory request and responses against the queues
   always @(negedge clock) begin
      cycExp_t  e;
      respExp_t r;
      logic     expValid;
      #2;
      if (cycQ.size() > 0) begin
         e = cycQ.pop_front();
         checkOutput("if_gnt", 32'(ifGnt), 32'(e.ifGnt));
         checkOutput("dm_gnt", 32'(dmGnt), 32'(e.dmGnt));
         checkOutput("pri_if_gnt", 32'(priIfGnt), 32'(e.priIfGnt));
         checkOutput("pri_dm_gnt", 32'(priDmGnt), 32'(e.priDmGnt));
         checkOutput("mem_rw_mode", 32'(memRw), 32'(e.rw));
         checkOutput("mem_byte_en", 32'(memBe), 32'(e.be));
         checkOutput("mem_wdata", memWdata, e.wd);
         if (e.chkAddr) checkOutput("mem_addr", 32'(memAddr), 32'(e.addr));
         expValid = (respQ.size() > 0) && (int'(respQ[0].cyc) == cycNow - 1);
         r = '0;
         if (expValid) r = respQ.pop_front();
         checkOutput("if_rvalid", 32'(ifRvalid), 32'(expValid && !r.isDm));
         checkOutput("dm_rvalid", 32'(dmRvalid), 32'(expValid && r.isDm));
         checkOutput("if_rdata", ifRdata, (expValid && !r.isDm) ? r.data : 32'h0);
         checkOutput("dm_rdata", dmRdata, (expValid && r.isDm) ? r.data : 32'h0);
         checkOutput("dm_err", 32'(dmErr), 32'(expValid && r.isDm && r.err));
         if (e.rstLate) begin
            #2;
            checkOutput("rst_mem_rw_mode", 32'(memRw), 32'h1);
            checkOutput("rst_mem_byte_en", 32'(memBe), 32'h0);
            checkOutput("rst_dm_gnt", 32'(dmGnt), 32'h0);
            checkOutput("rst_pri_dm_gnt", 32'(priDmGnt), 32'h0);
         end
      end
   end

   // Test sequence: directed cases, random traffic, reset in flight, conflicts
   initial begin
      for (int i = 0; i < 4096; i++) gold[i] = initByte(i);
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      fillMem = 1'b0;

      $display("[TB] directed IF fetch");
      ifDirQ.push_back(32'h0000_0010);
      repeat (2) applyStimulus(0, 0);

      $display("[TB] directed DM accesses");
      dmDirQ.push_back(mkDm(1'b1, 32'h0000_0103, 2'd0, 1'b0, 32'h0000_00A5));
      dmDirQ.push_back(mkDm(1'b1, 32'h0000_0100, 2'd2, 1'b0, 32'h0080_0000));
      dmDirQ.push_back(mkDm(1'b0, 32'h0000_0102, 2'd0, 1'b0, 32'h0));
      dmDirQ.push_back(mkDm(1'b0, 32'h0000_0102, 2'd0, 1'b1, 32'h0));
      dmDirQ.push_back(mkDm(1'b0, 32'h0000_0102, 2'd1, 1'b0, 32'h0));
      dmDirQ.push_back(mkDm(1'b0, 32'h0000_0006, 2'd2, 1'b0, 32'h0));
      dmDirQ.push_back(mkDm(1'b1, 32'h0000_0101, 2'd1, 1'b0, 32'h1234_5678));
      dmDirQ.push_back(mkDm(1'b1, 32'h0000_0100, 2'd3, 1'b0, 32'h1234_5678));
      dmDirQ.push_back(mkDm(1'b1, 32'hFFFF_F104, 2'd2, 1'b0, 32'hCAFE_F00D));
      dmDirQ.push_back(mkDm(1'b0, 32'h0000_0104, 2'd2, 1'b0, 32'h0));
      dmDirQ.push_back(mkDm(1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0));
      repeat (13) applyStimulus(0, 0);

      $display("[TB] random traffic");
      repeat (300) applyStimulus(60, 60);

      $display("[TB] reset with grant in flight");
      resetInFlight();

      $display("[TB] back-to-back conflicts");
      repeat (20) applyStimulus(100, 100);

      repeat (150) applyStimulus(50, 70);
      repeat (4) applyStimulus(0, 0);

      @(negedge clock);
      #5;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
